// File: rtl/multiply_if.sv
// Request/response bundle of the sequential multiplier: operands and start in,
// busy, result, destination and completion strobe out.
interface multiply_if;
  logic        start_i;
  logic        signed_i;
  logic        long_i;
  logic        accumulate_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic [63:0] acc_i;
  logic [3:0]  dest_i;
  logic        busy_o;
  logic [63:0] m_result_o;
  logic [3:0]  dest_o;
  logic        write_dest_m_o;
  logic        n_o;
  logic        z_o;

  modport master (
    output start_i, signed_i, long_i, accumulate_i, a_i, b_i, acc_i, dest_i,
    input  busy_o, m_result_o, dest_o, write_dest_m_o, n_o, z_o
  );

  modport slave (
    input  start_i, signed_i, long_i, accumulate_i, a_i, b_i, acc_i, dest_i,
    output busy_o, m_result_o, dest_o, write_dest_m_o, n_o, z_o
  );
endinterface

// File: rtl/multiply.sv
// Sequential 32x32 multiplier (one multiplier bit per cycle), optional signed
// operands, 32/64-bit result and accumulate, with N/Z flags.
module multiply (
  input  logic     clk,
  input  logic     rst,
  multiply_if.slave bus
);
  localparam int DATA_W = 32;

  typedef enum logic {IDLE, CALC} state_e;

  state_e state_q = IDLE;
  state_e state_d;
  logic [4:0] cnt_q = '0;
  logic       done;
  logic       accept;

  logic [2*DATA_W-1:0] mcand_p0;
  logic [DATA_W-1:0]   mplier_p0;
  logic [2*DATA_W-1:0] prod_p0;
  logic [2*DATA_W-1:0] acc_p0;
  logic                long_p0;
  logic                neg_p0;
  logic [3:0]          dest_p0;

  logic [2*DATA_W-1:0] prod_nxt;
  logic [2*DATA_W-1:0] result_nxt;

  logic [2*DATA_W-1:0] m_result_q = '0;
  logic [3:0]          dest_q     = '0;
  logic                strobe_q   = 1'b0;
  logic                n_q        = 1'b0;
  logic                z_q        = 1'b0;

  // Two's complement magnitude; 0x80000000 yields 0x80000000 read as unsigned 2^31.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                  input logic sgn);
    logic signed [DATA_W-1:0] neg_v;
    neg_v = -v;
    return (sgn && v[DATA_W-1]) ? DATA_W'(neg_v) : DATA_W'(v);
  endfunction

  function automatic logic [2*DATA_W-1:0] finalize(input logic [2*DATA_W-1:0] prod,
                                                   input logic neg,
                                                   input logic [2*DATA_W-1:0] acc,
                                                   input logic long_op);
    logic signed [2*DATA_W-1:0] p;
    logic [2*DATA_W-1:0] r;
    p = neg ? -$signed(prod) : $signed(prod);
    r = $unsigned(p) + acc;
    if (!long_op) r = {{DATA_W{1'b0}}, r[DATA_W-1:0]};
    return r;
  endfunction

  assign accept     = (state_q == IDLE) && bus.start_i;
  assign prod_nxt   = prod_p0 + (mplier_p0[0] ? mcand_p0 : '0);
  assign result_nxt = finalize(prod_nxt, neg_p0, acc_p0, long_p0);

  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    case (state_q)
      IDLE: if (bus.start_i) state_d = CALC;
      CALC: begin
        if (cnt_q == 5'd31) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      strobe_q   <= 1'b0;
      m_result_q <= '0;
      dest_q     <= '0;
      n_q        <= 1'b0;
      z_q        <= 1'b0;
    end else begin
      state_q  <= state_d;
      strobe_q <= done;
      if (accept) cnt_q <= '0;
      else if (state_q == CALC) cnt_q <= cnt_q + 5'd1;
      if (done) begin
        m_result_q <= result_nxt;
        dest_q     <= dest_p0;
        n_q        <= long_p0 ? result_nxt[2*DATA_W-1] : result_nxt[DATA_W-1];
        z_q        <= long_p0 ? (result_nxt == '0) : (result_nxt[DATA_W-1:0] == '0);
      end
    end
  end

  // Operand capture (p0) and shift-add datapath; held constant outside CALC.
  always_ff @(posedge clk) begin
    if (accept) begin
      mcand_p0  <= {{DATA_W{1'b0}}, magnitude($signed(bus.a_i), bus.signed_i)};
      mplier_p0 <= magnitude($signed(bus.b_i), bus.signed_i);
      prod_p0   <= '0;
      acc_p0    <= !bus.accumulate_i ? '0 :
                   bus.long_i ? bus.acc_i : {{DATA_W{1'b0}}, bus.acc_i[DATA_W-1:0]};
      long_p0   <= bus.long_i;
      neg_p0    <= bus.signed_i & (bus.a_i[DATA_W-1] ^ bus.b_i[DATA_W-1]);
      dest_p0   <= bus.dest_i;
    end else if (state_q == CALC) begin
      prod_p0   <= prod_nxt;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
    end
  end

  assign bus.busy_o         = (state_q == CALC);
  assign bus.m_result_o     = m_result_q;
  assign bus.dest_o         = dest_q;
  assign bus.write_dest_m_o = strobe_q;
  assign bus.n_o            = n_q;
  assign bus.z_o            = z_q;

endmodule

// File: tb/tb_multiply.sv
// Scoreboard bench for multiply: directed corner operations plus randomized
// operations checked against an arithmetic reference model.
module tb_multiply;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multiply_if bus();
  multiply dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [63:0] res;
    logic [3:0]  dest;
    logic        n;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t scb[$];
  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn, input logic lng,
                                        input logic accu, input logic [63:0] acc);
    longint sa, sbv;
    logic [63:0] p;
    if (sgn) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      p   = 64'(sa * sbv);
    end else begin
      p = {32'd0, a} * {32'd0, b};
    end
    if (accu) p = p + (lng ? acc : {32'd0, acc[31:0]});
    if (!lng) p[63:32] = 32'd0;
    return p;
  endfunction

  // Monitor: every completion strobe must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!rst && bus.write_dest_m_o === 1'b1) begin
      if (scb.size() == 0) begin
        check("unexpected_strobe", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = scb.pop_front();
        check("result", bus.m_result_o, e.res);
        check("dest", {60'd0, bus.dest_o}, {60'd0, e.dest});
        check("n_flag", {63'd0, bus.n_o}, {63'd0, e.n});
        check("z_flag", {63'd0, bus.z_o}, {63'd0, e.z});
        check("latency_cycle", 64'(cyc), 64'(e.cyc));
        check("busy_at_strobe", {63'd0, bus.busy_o}, 64'd0);
      end
    end
  end

  // Caller is at a negedge; waits for IDLE, then presents start for one edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       input logic lng, input logic accu, input logic [63:0] acc,
                       input logic [3:0] dest, input logic [63:0] exp_res);
    exp_t e;
    int guard = 0;
    while (bus.busy_o !== 1'b0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (bus.busy_o !== 1'b0) check("issue_wait_idle", {63'd0, bus.busy_o}, 64'd0);
    bus.a_i = a; bus.b_i = b; bus.signed_i = sgn; bus.long_i = lng;
    bus.accumulate_i = accu; bus.acc_i = acc; bus.dest_i = dest;
    bus.start_i = 1'b1;
    e.res  = exp_res;
    e.dest = dest;
    e.n    = lng ? exp_res[63] : exp_res[31];
    e.z    = lng ? (exp_res == 64'd0) : (exp_res[31:0] == 32'd0);
    e.cyc  = cyc + 33;
    scb.push_back(e);
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (scb.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_outstanding", 64'(scb.size()), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return 32'd1;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    logic s, l, ac;
    logic [63:0] acc;
    logic [3:0] d;
    int strobes;

    bus.start_i = 0; bus.signed_i = 0; bus.long_i = 0; bus.accumulate_i = 0;
    bus.a_i = 0; bus.b_i = 0; bus.acc_i = 0; bus.dest_i = 0;

    #1;
    check("t0_busy", {63'd0, bus.busy_o}, 64'd0);
    check("t0_strobe", {63'd0, bus.write_dest_m_o}, 64'd0);
    check("t0_result", bus.m_result_o, 64'd0);
    check("t0_dest", {60'd0, bus.dest_o}, 64'd0);
    check("t0_nz", {62'd0, bus.n_o, bus.z_o}, 64'd0);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {63'd0, bus.busy_o}, 64'd0);
    check("rst_result", bus.m_result_o, 64'd0);
    check("rst_flags_dest", {57'd0, bus.write_dest_m_o, bus.n_o, bus.z_o, bus.dest_o}, 64'd0);

    issue(32'd7, 32'd6, 0, 0, 0, 64'd0, 4'd5, 64'h0000_0000_0000_002A);
    issue(32'hFFFF_FFFF, 32'd1, 1, 1, 0, 64'd0, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1, 0, 64'd0, 4'd9, 64'hFFFF_FFFE_0000_0001);
    issue(32'd3, 32'd4, 0, 0, 1, 64'h0000_0000_FFFF_FFF4, 4'd1, 64'd0);
    issue(32'h8000_0000, 32'h8000_0000, 1, 1, 0, 64'd0, 4'd2, 64'h4000_0000_0000_0000);
    issue(32'h8000_0000, 32'd1, 1, 1, 0, 64'd0, 4'd4, 64'hFFFF_FFFF_8000_0000);
    issue(32'd2, 32'd3, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd6, 64'd5);
    drain();

    // Start pulsed mid-operation with different operands must be ignored.
    issue(32'd1000, 32'd1000, 0, 0, 0, 64'd0, 4'd7, 64'd1_000_000);
    repeat (5) @(negedge clk);
    bus.a_i = 32'd9; bus.b_i = 32'd9; bus.dest_i = 4'd12; bus.long_i = 1; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    drain();
    repeat (40) @(negedge clk);

    // Reset in the middle of an operation aborts it without a strobe.
    issue(32'd5, 32'd5, 0, 0, 0, 64'd0, 4'd11, 64'd25);
    drain();
    bus.a_i = 32'd123; bus.b_i = 32'd456; bus.dest_i = 4'd13; bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {63'd0, bus.busy_o}, 64'd0);
    check("abort_result", bus.m_result_o, 64'd0);
    check("abort_dest", {60'd0, bus.dest_o}, 64'd0);
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.write_dest_m_o === 1'b1) strobes++;
      @(negedge clk);
    end
    check("abort_strobes", 64'(strobes), 64'd0);

    for (int i = 0; i < 40; i++) begin
      a = pick(); b = pick();
      s = 1'($urandom_range(0, 1)); l = 1'($urandom_range(0, 1)); ac = 1'($urandom_range(0, 1));
      acc = {$urandom, $urandom};
      d = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) begin
        while (bus.busy_o === 1'b1) @(negedge clk);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      issue(a, b, s, l, ac, acc, d, model(a, b, s, l, ac, acc));
    end
    drain();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
